// File: rtl/spram_pkg.sv
// Shared definitions for the single-port RAM initiator and the RAM it drives.
// Holds the initiator state encoding and the default word width, depth and
// address width, so the initiator and the RAM agree on one geometry.
package spram_pkg;

    localparam int SPRAM_WIDTH = 8;
    localparam int SPRAM_ADDR  = 6;
    localparam int SPRAM_DEPTH = 2 ** SPRAM_ADDR;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WLAST = 2'd2,
        S_READ  = 2'd3
    } spram_state_t;

endpackage

// File: rtl/spram_initiator.sv
// Burst initiator for a single-port RAM with a shared bidirectional data bus.
//
// Ports
//   clk, rstn              clock, asynchronous active-low reset
//   req_valid/req_ready    burst request handshake
//   req_wr, req_addr,      direction (1 = write), start address and
//   req_len                beats minus one
//   wd_valid/wd_ready,     write-data handshake, one word per beat
//   wd_data
//   rd_valid, rd_data      one pulse per returned read word, no backpressure
//   done                   one-cycle pulse when a burst completes
//   cs, wr, addr, data     RAM side: chip select, write enable, address and
//                          shared data bus (driven only on write beats)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; RAM bus idle
// WRITE | accepting write words; each handshake becomes a bus beat
// WLAST | last write beat is on the bus; no more words accepted
// READ  | a read beat is on the bus every cycle until the count ends
module spram_initiator
    import spram_pkg::*;
#(
    parameter int WIDTH = SPRAM_WIDTH,
    parameter int DEPTH = SPRAM_DEPTH,
    parameter int ADDR  = SPRAM_ADDR
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [ADDR-1:0]  req_addr,
    input  logic [ADDR-1:0]  req_len,
    input  logic             wd_valid,
    output logic             wd_ready,
    input  logic [WIDTH-1:0] wd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             cs,
    output logic             wr,
    output logic [ADDR-1:0]  addr,
    inout  wire  [WIDTH-1:0] data
);

    spram_state_t     state_q, state_d;
    logic [ADDR-1:0]  nxt_addr_q, nxt_addr_d;
    logic [ADDR-1:0]  cnt_q, cnt_d;
    logic [ADDR-1:0]  len_q, len_d;
    logic             cs_q, cs_d;
    logic             wr_q, wr_d;
    logic [ADDR-1:0]  addr_q, addr_d;
    logic             drv_en_q, drv_en_d;
    logic [WIDTH-1:0] drv_val_q, drv_val_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             done_q, done_d;

    function automatic logic [ADDR-1:0] addr_inc(input logic [ADDR-1:0] a);
        return ADDR'((32'(a) + 32'd1) % DEPTH);
    endfunction

    // rstn is folded in so the ready flag is low for the whole reset window,
    // not just after the first edge.
    assign req_ready = rstn && (state_q == S_IDLE);
    assign wd_ready  = (state_q == S_WRITE);

    always_comb begin
        state_d    = state_q;
        nxt_addr_d = nxt_addr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        addr_d     = addr_q;
        drv_en_d   = 1'b0;
        drv_val_d  = drv_val_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    len_d = req_len;
                    cnt_d = '0;
                    if (req_wr) begin
                        state_d    = S_WRITE;
                        nxt_addr_d = req_addr;
                    end else begin
                        // First read beat goes out on the acceptance edge so
                        // READ cycles line up one-to-one with cs cycles.
                        state_d    = S_READ;
                        cs_d       = 1'b1;
                        addr_d     = req_addr;
                        nxt_addr_d = addr_inc(req_addr);
                    end
                end
            end

            S_READ: begin
                // The RAM drives the bus during this cycle; capture it on the
                // closing edge.
                rd_valid_d = 1'b1;
                rd_data_d  = data;
                if (cnt_q == len_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cs_d       = 1'b1;
                    addr_d     = nxt_addr_q;
                    nxt_addr_d = addr_inc(nxt_addr_q);
                    cnt_d      = cnt_q + ADDR'(1);
                end
            end

            S_WRITE: begin
                if (wd_valid) begin
                    cs_d       = 1'b1;
                    wr_d       = 1'b1;
                    addr_d     = nxt_addr_q;
                    drv_en_d   = 1'b1;
                    drv_val_d  = wd_data;
                    nxt_addr_d = addr_inc(nxt_addr_q);
                    if (cnt_q == len_q) begin
                        state_d = S_WLAST;
                    end else begin
                        cnt_d = cnt_q + ADDR'(1);
                    end
                end
            end

            S_WLAST: begin
                // Bus returns to idle here, which also provides the
                // turnaround cycle before the next burst.
                state_d = S_IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            nxt_addr_q <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            drv_en_q   <= 1'b0;
            drv_val_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            nxt_addr_q <= nxt_addr_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            drv_en_q   <= drv_en_d;
            drv_val_q  <= drv_val_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            done_q     <= done_d;
        end
    end

    assign cs       = cs_q;
    assign wr       = wr_q;
    assign addr     = addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign done     = done_q;

    assign data = drv_en_q ? drv_val_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_spram_initiator.sv
module tb_spram_initiator;
    import spram_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_valid, req_wr;
    logic       req_ready;
    logic [5:0] req_addr, req_len;
    logic       wd_valid, wd_ready;
    logic [7:0] wd_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       done, cs, wr;
    logic [5:0] addr;
    wire  [7:0] data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] mem    [64];
    logic [7:0] shadow [64];
    logic [7:0] rd_exp [$];
    logic [7:0] wq     [$];
    int         wl_addr[$];
    int         wl_data[$];
    int         wl_cyc [$];

    int done_cnt = 0, done_cyc = 0;
    int rdv_cnt = 0, rdv_first = 0, rdv_last = 0;
    int rd_cs_cnt = 0, rd_cs_first = 0, rd_cs_last = 0;
    logic prev_cs = 1'b0, prev_wr = 1'b0;

    spram_initiator dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .done      (done),
        .cs        (cs),
        .wr        (wr),
        .addr      (addr),
        .data      (data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: combinational read, write on the rising edge
    assign data = (cs && !wr) ? mem[addr] : 8'hzz;
    always @(posedge clk) if (cs && wr) mem[addr] <= data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // bus / output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rstn) begin
            prev_cs = 1'b0;
            prev_wr = 1'b0;
        end else begin
            if (!cs) chk("bus_z", 32'(data === 8'hzz), 32'd1);
            else     chk("bus_x", 32'($isunknown(data)), 32'd0);
            if (cs && prev_cs) chk("turnaround", 32'(wr), 32'(prev_wr));
            if (cs && wr) begin
                wl_addr.push_back(int'(addr));
                wl_data.push_back(int'(data));
                wl_cyc.push_back(cyc);
            end
            if (cs && !wr) begin
                if (rd_cs_cnt == 0) rd_cs_first = cyc;
                rd_cs_last = cyc;
                rd_cs_cnt++;
            end
            if (rd_valid) begin
                if (rdv_cnt == 0) rdv_first = cyc;
                rdv_last = cyc;
                rdv_cnt++;
                chk("rd_extra", 32'(rd_exp.size() != 0), 32'd1);
                if (rd_exp.size() != 0) chk("rd_data", 32'(rd_data), 32'(rd_exp.pop_front()));
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_cs = cs;
            prev_wr = wr;
        end
    end

    task automatic clear_logs();
        wl_addr.delete(); wl_data.delete(); wl_cyc.delete();
        rdv_cnt = 0; rd_cs_cnt = 0;
    endtask

    task automatic do_req(input logic w, input logic [5:0] a, input logic [5:0] l);
        int n = 0;
        req_valid = 1'b1; req_wr = w; req_addr = a; req_len = l;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 100) begin
                chk("req_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    // sends the words queued in wq, with 'gap' idle cycles between words
    task automatic run_write(input logic [5:0] a, input int gap);
        int d0;
        int n;
        int cnt;
        logic [5:0] ai;
        cnt = wq.size();
        do_req(1'b1, a, 6'(cnt - 1));
        d0 = done_cnt;
        for (int i = 0; i < cnt; i++) begin
            if (i > 0 && gap > 0) begin
                wd_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            wd_valid = 1'b1;
            wd_data  = wq[i];
            n = 0;
            forever begin
                @(negedge clk);
                if (wd_ready) break;
                n++;
                if (n > 100) begin
                    chk("wd_timeout", 32'd0, 32'd1);
                    break;
                end
            end
            @(posedge clk); #1;
            ai = a + 6'(i);
            shadow[ai] = wq[i];
        end
        wd_valid = 1'b0;
        wait_done(d0, "wr_done");
    endtask

    task automatic run_read(input logic [5:0] a, input logic [5:0] l);
        int d0;
        logic [5:0] ai;
        d0 = done_cnt;
        for (int i = 0; i <= int'(l); i++) begin
            ai = a + 6'(i);
            rd_exp.push_back(shadow[ai]);
        end
        do_req(1'b0, a, l);
        wait_done(d0, "rd_done");
        chk("rd_left", 32'(rd_exp.size()), 32'd0);
    endtask

    initial begin
        int d0;
        int n;
        logic [5:0] ra, rl;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        rstn = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        wd_valid = 1'b0; wd_data = '0;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cs", 32'(cs), 32'd0);
        chk("rst_bus", 32'(data === 8'hzz), 32'd1);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        #20 rstn = 1'b1;
        #1 chk("ready_after_rst", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // four-beat write at 0x10, words back-to-back
        clear_logs();
        wq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_write(6'h10, 0);
        chk("w4_beats", 32'(wl_addr.size()), 32'd4);
        if (wl_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("w4_addr", 32'(wl_addr[i]), 32'h10 + 32'(i));
                chk("w4_data", 32'(wl_data[i]), 32'(wq[i]));
                chk("w4_consec", 32'(wl_cyc[i] - wl_cyc[0]), 32'(i));
            end
            chk("w4_done_pos", 32'(done_cyc), 32'(wl_cyc[3] + 1));
        end

        // read the same four words back
        clear_logs();
        run_read(6'h10, 6'd3);
        chk("r4_cs", 32'(rd_cs_cnt), 32'd4);
        chk("r4_cs_consec", 32'(rd_cs_last - rd_cs_first), 32'd3);
        chk("r4_rdv", 32'(rdv_cnt), 32'd4);
        chk("r4_rdv_lat", 32'(rdv_first), 32'(rd_cs_first + 1));
        chk("r4_done_align", 32'(done_cyc), 32'(rdv_last));

        // two-beat write across the wrap with a two-cycle gap
        clear_logs();
        wq = '{8'h5A, 8'h6B};
        run_write(6'h3F, 2);
        chk("wrap_beats", 32'(wl_addr.size()), 32'd2);
        if (wl_addr.size() == 2) begin
            chk("wrap_addr0", 32'(wl_addr[0]), 32'h3F);
            chk("wrap_addr1", 32'(wl_addr[1]), 32'h00);
            chk("wrap_gap", 32'(wl_cyc[1] - wl_cyc[0]), 32'd3);
        end
        clear_logs();
        run_read(6'h3F, 6'd1);
        chk("wrap_rdv", 32'(rdv_cnt), 32'd2);

        // read immediately followed by a write request
        clear_logs();
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) rd_exp.push_back(shadow[6'h10 + 6'(i)]);
        do_req(1'b0, 6'h10, 6'd2);
        wq = '{8'h11, 8'h22};
        run_write(6'h30, 0);
        chk("rw_dones", 32'(done_cnt - d0), 32'd2);
        chk("rw_rd_left", 32'(rd_exp.size()), 32'd0);
        if (wl_cyc.size() > 0) chk("rw_turn_gap", 32'((wl_cyc[0] - rd_cs_last) >= 2), 32'd1);
        else chk("rw_wbeats", 32'(wl_cyc.size()), 32'd2);

        // a few random write/read-back pairs
        for (int k = 0; k < 3; k++) begin
            ra = 6'($urandom_range(63));
            rl = 6'($urandom_range(7));
            wq.delete();
            for (int i = 0; i <= int'(rl); i++) wq.push_back(8'($urandom));
            clear_logs();
            run_write(ra, int'($urandom_range(1)));
            chk("rnd_wbeats", 32'(wl_addr.size()), 32'(rl) + 32'd1);
            clear_logs();
            run_read(ra, rl);
            chk("rnd_rdv", 32'(rdv_cnt), 32'(rl) + 32'd1);
        end

        // reset in the middle of an eight-beat write at 0x20
        d0 = done_cnt;
        do_req(1'b1, 6'h20, 6'd7);
        wd_valid = 1'b1;
        wd_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            n = 0;
            forever begin
                @(negedge clk);
                if (wd_ready || n > 100) break;
                n++;
            end
            @(posedge clk); #1;
            wd_data = wd_data + 8'd1;
        end
        #1 rstn = 1'b0;
        #1;
        chk("abort_cs", 32'(cs), 32'd0);
        chk("abort_wr", 32'(wr), 32'd0);
        chk("abort_addr", 32'(addr), 32'd0);
        chk("abort_bus", 32'(data === 8'hzz), 32'd1);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_wdr", 32'(wd_ready), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rdd", 32'(rd_data), 32'd0);
        wd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rstn = 1'b1;
        #1 chk("abort_ready_rel", 32'(req_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1 chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        clear_logs();
        run_read(6'h23, 6'd4);
        chk("abort_rdv", 32'(rdv_cnt), 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spram_initiator.md
SPRAM_INITIATOR -- requirements
Module: spram_initiator

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8, as the data word width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 64, as the number of RAM words.
REQ-003 The block SHALL take parameter ADDR, default 6, as the address width; DEPTH = 2**ADDR.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rstn  input  1  reset; asynchronous and active-low.
REQ-006 req_valid  input  1  a request is offered.
REQ-007 req_ready  output  1  the block can accept a request.
REQ-008 req_wr  input  1  request direction: 1 = write burst, 0 = read burst.
REQ-009 req_addr  input  ADDR  start address.
REQ-010 req_len  input  ADDR  burst length minus one, giving 1..DEPTH beats.
REQ-011 wd_valid  input  1  write data word offered.
REQ-012 wd_ready  output  1  write data word can be accepted.
REQ-013 wd_data  input  WIDTH  write data word.
REQ-014 rd_valid  output  1  rd_data holds a read word; one-cycle pulse per beat; no backpressure.
REQ-015 rd_data  output  WIDTH  read word.
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 cs  output  1  RAM chip select.
REQ-018 wr  output  1  RAM write enable.
REQ-019 addr  output  ADDR  RAM address.
REQ-020 data  inout  WIDTH  shared RAM data bus.

Function
REQ-021 The block SHALL implement states IDLE, WRITE, WLAST and READ.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on the edge where req_valid and req_ready are both 1.
REQ-023 On acceptance, the block SHALL latch req_addr and req_len, clear the beat counter, and enter READ (req_wr=0) or WRITE (req_wr=1).
REQ-024 All RAM-side outputs (cs, wr, addr, data-drive enable and drive value) SHALL be registered.
REQ-025 READ: each cycle drives cs=1, wr=0 and addr=current address, with data released to high-Z.
REQ-026 READ: each cycle samples data on its closing edge; rd_valid=1 and rd_data=sampled word in the next cycle.
REQ-027 An N-beat read SHALL hold cs high for exactly N consecutive cycles.
REQ-028 An N-beat read SHALL return rd_valid exactly N times, starting one cycle after the first cs cycle.
REQ-029 WRITE: wd_ready SHALL be 1.
REQ-030 WRITE: each wd_valid&&wd_ready edge SHALL produce, in the next cycle, cs=1, wr=1, addr=current address, with data driven to the accepted word.
REQ-031 WRITE: a cycle without a handshake SHALL produce cs=0, wr=0 and the bus at high-Z in the next cycle (stall).
REQ-032 The handshake for the last beat SHALL move the state to WLAST, in which wd_ready=0 and the last beat is on the bus.
REQ-033 WLAST SHALL return to IDLE after one cycle.
REQ-034 The address SHALL increment after every bus beat and wrap modulo DEPTH (e.g. 63 -> 0).
REQ-035 Read completion: done SHALL pulse in the same cycle as the last rd_valid, with the state back in IDLE.
REQ-036 Write completion: done SHALL pulse in the first IDLE cycle after WLAST.
REQ-037 data SHALL be driven only in cycles with cs=1 and wr=1, and be high-Z at all other times.
REQ-038 At least one cs=0 cycle SHALL separate any two bursts, as bus turnaround.
REQ-039 wd_valid SHALL be ignored outside WRITE.
REQ-040 Request inputs SHALL be ignored outside IDLE.

Reset
REQ-041 While rstn=0, all of the following SHALL hold immediately, independent of clk:
- state = IDLE
- cs = 0, wr = 0, addr = 0, data bus high-Z
- req_ready = 0
- wd_ready = 0, rd_valid = 0, rd_data = 0, done = 0
REQ-042 Reset during a burst SHALL abort the burst with no done pulse and no resumption.
REQ-043 req_ready SHALL rise in the first cycle after rstn deasserts.

Structure
REQ-044 A shared package spram_pkg SHALL hold the state encodings and the default WIDTH/DEPTH/ADDR values used by this block and the RAM.
REQ-045 The block SHALL be a single module with no sub-modules; the tri-state driver is a continuous assignment inside it.

Verification
REQ-046 Write len=3 at addr=0x10 with words A1,B2,C3,D4 offered back-to-back against the RAM model -> cs/wr high for 4 consecutive cycles at addresses 0x10..0x13, then done pulses once.
REQ-047 Read len=3 at addr=0x10 after REQ-046 -> cs high for 4 cycles, rd_valid for 4 cycles returning A1,B2,C3,D4, with done coinciding with D4.
REQ-048 Write len=1 at addr=0x3F with a 2-cycle wd_valid gap between words -> beats at 0x3F and 0x00, cs=0 with the bus at high-Z during the gap, and a subsequent read returns both words.
REQ-049 Read then write issued back-to-back -> at least one cs=0 cycle between them, and the data bus is never driven by both ends (no X on data).
REQ-050 rstn asserted in the middle of an 8-beat write -> cs=0 and bus high-Z immediately, no done pulse, req_ready=1 one cycle after release, and the next read returns the reset contents (0x00).
